carus_clk_gate_ctrl: RTL and testbench
======================================

// Module: carus_clk_gate_ctrl
//
// PURPOSE
// Free-running-clock controller that generates the enable for the carus clock-gating wrapper.
// - Opens the carus clock on demand and grants requests only after a settle window.
// - Closes the clock after a programmable idle timeout.
// - Counts gated cycles for power profiling.
// - Sits between the bus/accelerator control and the gating cell; runs on the ungated clock.
//
// PARAMETERS
// WAKE_CYCLES  2   cycles clk_en_o is high before gnt_o may assert; legal range >= 1
// IDLE_CYCLES  16  consecutive inactive cycles in IDLE before the clock closes; legal range >= 1
// CNT_W        $clog2(max(WAKE_CYCLES,IDLE_CYCLES)+1)  width of the shared down-counter
//
// PORTS
// clk_i          in   1   ungated clock
// rst_i          in   1   asynchronous reset, active-high
// req_i          in   1   request for the carus clock; held until gnt_o
// busy_i         in   1   carus busy; keeps the clock open, never granted
// force_en_i     in   1   SW override; clock stays open while high
// stat_clr_i     in   1   synchronous clear of gated_cnt_o
// clk_en_o       out  1   enable to the gating cell (en_i); driven directly from a flop
// gnt_o          out  1   request granted; clock is stable
// state_o        out  2   FSM state: 0=OFF 1=WAKE 2=ON 3=IDLE
// gated_cnt_o    out  32  saturating count of cycles spent in OFF
//
// BEHAVIOUR
// - Reset values: state=OFF, clk_en_o=0, counter=0, gated_cnt_o=0, gnt_o=0.
// - act = req_i | busy_i | force_en_i, sampled on every clk_i rising edge.
// - OFF:
//   - act=1 -> WAKE; counter loads WAKE_CYCLES-1.
//   - otherwise stay in OFF.
// - WAKE:
//   - Counter decrements each cycle; counter==0 -> ON.
//   - Inputs are ignored, so WAKE always completes even if act drops.
// - ON:
//   - act=0 -> IDLE; counter loads IDLE_CYCLES-1.
//   - otherwise stay in ON.
// - IDLE:
//   - act=1 -> ON. This has priority over the timeout when both occur in the same cycle.
//   - otherwise counter==0 -> OFF; else decrement.
// - clk_en_o flop is loaded with (next_state != OFF), so it equals (state != OFF) every cycle.
//   - The enable is glitch-free, with no combinational decode on the output.
// - gnt_o = req_i & (state==ON | state==IDLE); combinational and only with a running clock.
//   - A request in IDLE is granted in that same cycle, and the FSM returns to ON.
// - Latency from OFF, with req_i seen at edge N:
//   - clk_en_o=1 from cycle N+1.
//   - state=ON and gnt_o=1 at cycle N+1+WAKE_CYCLES.
// - Close latency from ON, with act last high at cycle M:
//   - IDLE at M+1.
//   - OFF and clk_en_o=0 at M+1+IDLE_CYCLES.
// - gated_cnt_o:
//   - +1 on each cycle with state==OFF.
//   - Saturates at 32'hFFFF_FFFF.
//   - stat_clr_i wins over increment and sets it to 0 on the next edge.
// - Reset asserted mid-operation:
//   - Immediate return to OFF with clk_en_o=0.
//   - An outstanding req_i must be re-presented; after reset release it gets a full WAKE.
// - Illegal states cannot occur because the 2-bit encoding is fully used.
// - scan gating is outside this block (the gating wrapper's test enable).
//
// TESTING
// 1. Reset, hold act=0 for 10 cycles -> clk_en_o=0, state_o=0, gated_cnt_o=10.
// 2. req_i=1 at edge 0, WAKE_CYCLES=2 -> clk_en_o=1 at cycle 1, state_o=2 and gnt_o=1 at cycle 3.
// 3. From ON, drop all act at cycle 0, IDLE_CYCLES=16 -> state_o=3 at 1, clk_en_o=0 and state_o=0 at 17.
// 4. IDLE with counter==0 and req_i=1 same cycle -> gnt_o=1 that cycle, state_o=2 next, clk_en_o stays 1.
// 5. force_en_i=1 for 100 cycles, no req -> clock open throughout, gnt_o=0; release -> OFF after 1+IDLE_CYCLES.
// 6. Assert rst_i during WAKE -> clk_en_o=0 asynchronously; stat_clr_i with state OFF -> gated_cnt_o=0 next cycle.

Source files
------------

// File: rtl/carus_clk_gate_ctrl.sv
// carus_clk_gate_ctrl
//
// Generates the enable for the carus clock-gating wrapper. Runs on the
// ungated clock. On demand it opens the gated clock and waits a settle
// window before it grants a request. It closes the clock after an idle
// timeout, and it counts the cycles spent with the clock closed so power
// can be profiled.
//
// Ports
//   clk_i        ungated clock
//   rst_i        asynchronous reset, active-high
//   req_i        request for the carus clock, held until gnt_o
//   busy_i       carus busy; keeps the clock open but is never granted
//   force_en_i   software override; the clock stays open while this is high
//   stat_clr_i   synchronous clear of gated_cnt_o
//   clk_en_o     enable to the gating cell, driven straight from a flop
//   gnt_o        request granted (the clock is running and stable)
//   state_o      FSM state: 0=OFF 1=WAKE 2=ON 3=IDLE
//   gated_cnt_o  saturating count of cycles spent in OFF
//
// State table
//   state | meaning
//   OFF   | clock gated; gated_cnt_o counts these cycles
//   WAKE  | clock enabled and settling; inputs ignored until the counter expires
//   ON    | clock running; requests are granted
//   IDLE  | clock running with no activity; the idle timeout is counting down

module carus_clk_gate_ctrl #(
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 16,
  parameter int CNT_W = $clog2(((WAKE_CYCLES > IDLE_CYCLES) ? WAKE_CYCLES : IDLE_CYCLES) + 1)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        busy_i,
  input  logic        force_en_i,
  input  logic        stat_clr_i,
  output logic        clk_en_o,
  output logic        gnt_o,
  output logic [1:0]  state_o,
  output logic [31:0] gated_cnt_o
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_IDLE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_en_q, clk_en_d;
  logic [31:0]      gated_cnt_q, gated_cnt_d;
  logic             act;

  assign act = req_i | busy_i | force_en_i;

  // State register, together with the shared down-counter, the enable flop
  // and the statistics counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      clk_en_q    <= 1'b0;
      gated_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clk_en_q    <= clk_en_d;
      gated_cnt_q <= gated_cnt_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_OFF: begin
        if (act) begin
          state_d = ST_WAKE;
          cnt_d   = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        // WAKE always runs to completion, so the clock is not dropped
        // while it is still settling.
        if (cnt_q == '0) state_d = ST_ON;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      ST_ON: begin
        if (!act) begin
          state_d = ST_IDLE;
          cnt_d   = IDLE_LOAD;
        end
      end
      ST_IDLE: begin
        // New activity takes priority over a timeout that expires in the
        // same cycle, because that request has already been granted.
        if (act)                state_d = ST_ON;
        else if (cnt_q == '0)   state_d = ST_OFF;
        else                    cnt_d   = cnt_q - CNT_ONE;
      end
      default: state_d = ST_OFF;
    endcase

    // Loading the flop from the next state makes clk_en_o equal
    // (state != OFF) with no decode on the output path.
    clk_en_d = (state_d != ST_OFF);

    gated_cnt_d = gated_cnt_q;
    if (stat_clr_i)
      gated_cnt_d = '0;
    else if ((state_q == ST_OFF) && (gated_cnt_q != 32'hFFFF_FFFF))
      gated_cnt_d = gated_cnt_q + 32'd1;
  end

  // Output logic
  always_comb begin
    gnt_o       = req_i & ((state_q == ST_ON) | (state_q == ST_IDLE));
    state_o     = state_q;
    clk_en_o    = clk_en_q;
    gated_cnt_o = gated_cnt_q;
  end

endmodule

// File: tb/tb_carus_clk_gate_ctrl.sv
module tb_carus_clk_gate_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        busy_i;
  logic        force_en_i;
  logic        stat_clr_i;
  logic        clk_en_o;
  logic        gnt_o;
  logic [1:0]  state_o;
  logic [31:0] gated_cnt_o;

  int errors = 0;
  int checks = 0;

  carus_clk_gate_ctrl #(.WAKE_CYCLES(2), .IDLE_CYCLES(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .busy_i      (busy_i),
    .force_en_i  (force_en_i),
    .stat_clr_i  (stat_clr_i),
    .clk_en_o    (clk_en_o),
    .gnt_o       (gnt_o),
    .state_o     (state_o),
    .gated_cnt_o (gated_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_i = 1'b0; busy_i = 1'b0; force_en_i = 1'b0; stat_clr_i = 1'b0;
    tick(2);
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    checks++; if (clk_en_o !== 1'b0) begin errors++; $display("FAIL reset_clk_en got=%0b exp=0", clk_en_o); end
    checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL reset_gnt got=%0b exp=0", gnt_o); end
    checks++; if (gated_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_gated got=%0d exp=0", gated_cnt_o); end
    rst_i = 1'b0;
    tick(10);
    checks++; if (gated_cnt_o !== 32'd10) begin errors++; $display("FAIL off_gated10 got=%0d exp=10", gated_cnt_o); end
    checks++; if (clk_en_o !== 1'b0) begin errors++; $display("FAIL off_clk_en got=%0b exp=0", clk_en_o); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL off_state got=%0d exp=0", state_o); end
  endtask

  task automatic test_wake();
    req_i = 1'b1;
    tick(1);
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL wake_state1 got=%0d exp=1", state_o); end
    checks++; if (clk_en_o !== 1'b1) begin errors++; $display("FAIL wake_clk_en got=%0b exp=1", clk_en_o); end
    checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL wake_gnt1 got=%0b exp=0", gnt_o); end
    checks++; if (gated_cnt_o !== 32'd11) begin errors++; $display("FAIL wake_gated got=%0d exp=11", gated_cnt_o); end
    tick(1);
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL wake_state2 got=%0d exp=1", state_o); end
    checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL wake_gnt2 got=%0b exp=0", gnt_o); end
    tick(1);
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL wake_on got=%0d exp=2", state_o); end
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL wake_gnt3 got=%0b exp=1", gnt_o); end
    checks++; if (gated_cnt_o !== 32'd11) begin errors++; $display("FAIL on_gated_hold got=%0d exp=11", gated_cnt_o); end
  endtask

  task automatic test_idle_close();
    req_i = 1'b0;
    tick(1);
    checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL idle_enter got=%0d exp=3", state_o); end
    tick(15);
    checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL idle_hold got=%0d exp=3", state_o); end
    checks++; if (clk_en_o !== 1'b1) begin errors++; $display("FAIL idle_clk_en got=%0b exp=1", clk_en_o); end
    tick(1);
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL idle_off got=%0d exp=0", state_o); end
    checks++; if (clk_en_o !== 1'b0) begin errors++; $display("FAIL idle_off_clk_en got=%0b exp=0", clk_en_o); end
    tick(1);
    checks++; if (gated_cnt_o !== 32'd12) begin errors++; $display("FAIL off_gated12 got=%0d exp=12", gated_cnt_o); end
  endtask

  task automatic test_idle_priority();
    req_i = 1'b1;
    tick(3);
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL prio_on got=%0d exp=2", state_o); end
    req_i = 1'b0;
    tick(16);
    checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL prio_idle_last got=%0d exp=3", state_o); end
    req_i = 1'b1;
    #1;
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL prio_gnt_idle got=%0b exp=1", gnt_o); end
    tick(1);
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL prio_back_on got=%0d exp=2", state_o); end
    checks++; if (clk_en_o !== 1'b1) begin errors++; $display("FAIL prio_clk_en got=%0b exp=1", clk_en_o); end
    req_i = 1'b0;
    tick(17);
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL prio_close got=%0d exp=0", state_o); end
  endtask

  task automatic test_wake_ignores_act();
    req_i = 1'b1;
    tick(1);
    req_i = 1'b0;
    tick(1);
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL wignore_wake got=%0d exp=1", state_o); end
    tick(1);
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL wignore_on got=%0d exp=2", state_o); end
    tick(1);
    checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL wignore_idle got=%0d exp=3", state_o); end
    tick(16);
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL wignore_off got=%0d exp=0", state_o); end
  endtask

  task automatic test_force();
    int bad = 0;
    force_en_i = 1'b1;
    tick(1);
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL force_wake got=%0d exp=1", state_o); end
    for (int i = 0; i < 100; i++) begin
      tick(1);
      checks++;
      if (clk_en_o !== 1'b1 || gnt_o !== 1'b0) begin
        errors++;
        if (bad < 3) $display("FAIL force_open cyc=%0d clk_en=%0b gnt=%0b exp clk_en=1 gnt=0", i, clk_en_o, gnt_o);
        bad++;
      end
    end
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL force_on got=%0d exp=2", state_o); end
    force_en_i = 1'b0;
    tick(1);
    checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL force_idle got=%0d exp=3", state_o); end
    tick(15);
    checks++; if (clk_en_o !== 1'b1) begin errors++; $display("FAIL force_idle_clk_en got=%0b exp=1", clk_en_o); end
    tick(1);
    checks++; if (state_o !== 2'd0 || clk_en_o !== 1'b0) begin errors++; $display("FAIL force_close state=%0d clk_en=%0b exp 0/0", state_o, clk_en_o); end
  endtask

  task automatic test_busy();
    busy_i = 1'b1;
    tick(3);
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL busy_on got=%0d exp=2", state_o); end
    checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL busy_no_gnt got=%0b exp=0", gnt_o); end
    req_i = 1'b1;
    #1;
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL busy_req_gnt got=%0b exp=1", gnt_o); end
    req_i = 1'b0; busy_i = 1'b0;
    tick(1);
    checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL busy_idle got=%0d exp=3", state_o); end
    busy_i = 1'b1;
    tick(1);
    checks++; if (state_o !== 2'd2 || gnt_o !== 1'b0) begin errors++; $display("FAIL busy_reopen state=%0d gnt=%0b exp 2/0", state_o, gnt_o); end
    busy_i = 1'b0;
    tick(17);
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL busy_close got=%0d exp=0", state_o); end
  endtask

  task automatic test_reset_mid();
    req_i = 1'b1;
    tick(1);
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL rmid_wake got=%0d exp=1", state_o); end
    #2 rst_i = 1'b1;
    #1;
    checks++; if (clk_en_o !== 1'b0) begin errors++; $display("FAIL rmid_clk_en got=%0b exp=0", clk_en_o); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL rmid_state got=%0d exp=0", state_o); end
    checks++; if (gated_cnt_o !== 32'd0) begin errors++; $display("FAIL rmid_gated got=%0d exp=0", gated_cnt_o); end
    tick(1);
    rst_i = 1'b0;
    tick(1);
    checks++; if (state_o !== 2'd1 || clk_en_o !== 1'b1) begin errors++; $display("FAIL rmid_rewake state=%0d clk_en=%0b exp 1/1", state_o, clk_en_o); end
    tick(1);
    checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL rmid_gnt_early got=%0b exp=0", gnt_o); end
    tick(1);
    checks++; if (state_o !== 2'd2 || gnt_o !== 1'b1) begin errors++; $display("FAIL rmid_on state=%0d gnt=%0b exp 2/1", state_o, gnt_o); end
    req_i = 1'b0;
    tick(17);
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL rmid_close got=%0d exp=0", state_o); end
  endtask

  task automatic test_stat_clr();
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    tick(5);
    checks++; if (gated_cnt_o !== 32'd5) begin errors++; $display("FAIL clr_pre got=%0d exp=5", gated_cnt_o); end
    stat_clr_i = 1'b1;
    tick(1);
    checks++; if (gated_cnt_o !== 32'd0) begin errors++; $display("FAIL clr_zero got=%0d exp=0", gated_cnt_o); end
    tick(1);
    checks++; if (gated_cnt_o !== 32'd0) begin errors++; $display("FAIL clr_hold got=%0d exp=0", gated_cnt_o); end
    stat_clr_i = 1'b0;
    tick(1);
    checks++; if (gated_cnt_o !== 32'd1) begin errors++; $display("FAIL clr_resume got=%0d exp=1", gated_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_wake();
    test_idle_close();
    test_idle_priority();
    test_wake_ignores_act();
    test_force();
    test_busy();
    test_reset_mid();
    test_stat_clr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
